fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter IMEM_WORDS, default 128: instruction memory depth in 32-bit words; legal fetch range is 0 to IMEM_WORDS*4-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instraddr  output  32  byte address to instruction memory; combinational copy of the PC register.
REQ-006 instruction  input  32  word returned combinationally by instruction memory for instraddr.
REQ-007 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-008 redirect_target  input  32  redirect byte address.
REQ-009 out_valid  output  1  out_* holds a fetched instruction.
REQ-010 out_ready  input  1  downstream decoder accepts out_* this cycle.
REQ-011 out_instr  output  32  fetched instruction word.
REQ-012 out_pc  output  32  address of out_instr.
REQ-013 out_pc_plus4  output  32  out_pc+4, modulo 2^32.
REQ-014 fetch_fault  output  1  fetch halted on an illegal address.
REQ-015 fetch_count  output  32  number of handshakes completed (out_valid && out_ready).

Function
REQ-016 FSM states: BOOT, RUN, FAULT.
REQ-017 BOOT lasts exactly one cycle after reset release, then moves to RUN; no fetch occurs in BOOT.
REQ-018 In RUN, when out_valid==0 or out_ready==1, with no redirect: out_instr<=instruction, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
REQ-019 In RUN, when out_valid==1 and out_ready==0: pc and out_* hold.
REQ-020 If out_ready==1 and no new fetch occurs, out_valid<=0.
REQ-021 redirect_valid has priority over stall and fetch in every state: pc<=redirect_target, out_valid<=0, state<=RUN, fetch_fault<=0.
REQ-022 Fetch latency: an instruction at pc appears on out_* one cycle after pc is presented; sustained throughput is one instruction per cycle.
REQ-023 In RUN, pc >= IMEM_WORDS*4 with no redirect: no fetch, state<=FAULT, fetch_fault<=1; an already valid out_* entry still drains normally.
REQ-024 FAULT is sticky; only redirect or reset leaves it.
REQ-025 pc+4 wraps modulo 2^32.
REQ-026 fetch_count increments by 1 per completed handshake and wraps from 32'hFFFF_FFFF to 0.
REQ-027 A handshake and a redirect in the same cycle: the handshake counts, then out_valid<=0.

Reset
REQ-028 Asynchronous assertion of rst_n=0 sets pc=RESET_PC, state=BOOT, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fetch_fault=0, fetch_count=0, mid-operation included.
REQ-029 instraddr equals RESET_PC while in reset.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN.
REQ-031 Defined: redirect_target[1:0]!=0 loads pc and enters FAULT with fetch_fault<=1 on the next edge.
REQ-032 Undefined: redirect_target[1:0] is forced to 0 when loaded into pc; no fault results from misalignment.

Structure
REQ-033 A shared package holds the FSM state enum (BOOT, RUN, FAULT), the XLEN=32 constant, and the default RESET_PC constant.
REQ-034 One sub-module, fetch_pc_reg, holds the PC register and next-PC mux; the FSM, output register and counter stay in fetch_unit.

Verification
REQ-035 Reset with RESET_PC=0 and out_ready=1 held -> out_pc sequence 0,4,8,... starts two cycles after reset release; fetch_count reaches 3 after three handshakes.
REQ-036 out_ready=0 for 3 cycles with out_pc=8 -> out_pc, out_instr and instraddr (=12) stable; one handshake after release.
REQ-037 redirect_valid with target 0x40 while stalled -> out_valid=0 the next cycle; out_pc=0x40 the cycle after.
REQ-038 IMEM_WORDS=4 -> after out_pc=12, fetch_fault=1 and out_valid drops; redirect to 0 clears the fault and resumes fetch.
REQ-039 FETCH_MISALIGN_CHECK_EN defined, redirect to 0x42 -> fetch_fault=1. Undefined -> out_pc=0x40.
REQ-040 rst_n=0 asynchronously mid-stream -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width,
// default reset PC and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux.
// A redirect load wins over a sequential advance; otherwise the PC holds.
// The +4 increment wraps naturally modulo 2^32.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_addr,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-PC selection: redirect, sequential step, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_valid) begin
            pc_d = load_addr;
        end else if (advance) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: BOOT/RUN/FAULT sequencer, one-entry output
// register towards the decoder with valid/ready handshake, and a
// handshake counter.
// Optional build macro FETCH_MISALIGN_CHECK_EN: when defined, a redirect
// to a non word-aligned target is loaded as-is and faults; when undefined
// the two low target bits are cleared and no fault results.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              IMEM_WORDS = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] instraddr,
    input  logic [XLEN-1:0] instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fetch_count
);

    // One extra bit so IMEM_WORDS*4 == 2^32 would still compare correctly.
    localparam int              LIMIT_W     = XLEN + 1;
    localparam logic [XLEN:0]   FETCH_LIMIT = LIMIT_W'(IMEM_WORDS) * LIMIT_W'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] REDIRECT_MASK = '1;
`else
    localparam logic [XLEN-1:0] REDIRECT_MASK = ~XLEN'(3);
`endif

    fetch_state_e    state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_pc_plus4_q, out_pc_plus4_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc;
    logic            fetch_en;
    logic            handshake;
    logic            can_accept;
    logic            in_range;
    logic            redirect_misaligned;

    assign handshake  = out_valid_q && out_ready;
    assign can_accept = !out_valid_q || out_ready;
    assign in_range   = {1'b0, pc} < FETCH_LIMIT;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_misaligned = |redirect_target[1:0];
`else
    assign redirect_misaligned = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (redirect_valid),
        .load_addr  (redirect_target & REDIRECT_MASK),
        .advance    (fetch_en),
        .pc         (pc)
    );

    // Sequencer and output-register next-state: redirect first, then per-state behaviour.
    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        fetch_fault_d  = fetch_fault_q;
        fetch_count_d  = fetch_count_q + XLEN'(handshake);
        fetch_en       = 1'b0;
        if (redirect_valid) begin
            out_valid_d   = 1'b0;
            state_d       = redirect_misaligned ? FAULT : RUN;
            fetch_fault_d = redirect_misaligned;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (!in_range) begin
                        // Stop fetching but let a pending entry drain.
                        state_d       = FAULT;
                        fetch_fault_d = 1'b1;
                        if (out_ready) begin
                            out_valid_d = 1'b0;
                        end
                    end else if (can_accept) begin
                        fetch_en       = 1'b1;
                        out_valid_d    = 1'b1;
                        out_instr_d    = instruction;
                        out_pc_d       = pc;
                        out_pc_plus4_d = pc + XLEN'(4);
                    end
                end
                FAULT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State, output register and counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
            fetch_fault_q  <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            fetch_fault_q  <= fetch_fault_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign instraddr    = pc;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign fetch_fault  = fetch_fault_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table on a 128-word
// instance, plus hand sequences for asynchronous reset and the fault
// path of a 4-word instance. Both instances share the stimulus.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_ready;

    logic [31:0] m_addr, m_instr_in, m_instr, m_pc, m_pc4, m_cnt;
    logic        m_valid, m_fault;
    logic [31:0] s_addr, s_instr_in, s_instr, s_pc, s_pc4, s_cnt;
    logic        s_valid, s_fault;

    int total = 0;
    int bad   = 0;

    // Instruction memory content model: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    assign m_instr_in = imem(m_addr);
    assign s_instr_in = imem(s_addr);

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
        .clk(clk), .rst_n(rst_n), .instraddr(m_addr), .instruction(m_instr_in),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(m_valid), .out_ready(out_ready), .out_instr(m_instr),
        .out_pc(m_pc), .out_pc_plus4(m_pc4), .fetch_fault(m_fault), .fetch_count(m_cnt)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .instraddr(s_addr), .instruction(s_instr_in),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(s_valid), .out_ready(out_ready), .out_instr(s_instr),
        .out_pc(s_pc), .out_pc_plus4(s_pc4), .fetch_fault(s_fault), .fetch_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic d, input logic [31:0] t,
                                input logic v, input logic [31:0] p, input logic [31:0] a,
                                input logic f, input logic [31:0] c);
        vec_t x;
        x.rdy = r; x.redir = d; x.tgt = t; x.e_valid = v;
        x.e_pc = p; x.e_addr = a; x.e_fault = f; x.e_cnt = c;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input vec_t v);
        chk({tag, " valid"}, 32'(m_valid), 32'(v.e_valid));
        chk({tag, " instraddr"}, m_addr, v.e_addr);
        chk({tag, " fault"}, 32'(m_fault), 32'(v.e_fault));
        chk({tag, " count"}, m_cnt, v.e_cnt);
        if (v.e_valid) begin
            chk({tag, " out_pc"}, m_pc, v.e_pc);
            chk({tag, " out_instr"}, m_instr, imem(v.e_pc));
            chk({tag, " out_pc_plus4"}, m_pc4, v.e_pc + 32'd4);
        end
    endtask

    task automatic check_small(input string tag, input vec_t v);
        chk({tag, " valid"}, 32'(s_valid), 32'(v.e_valid));
        chk({tag, " instraddr"}, s_addr, v.e_addr);
        chk({tag, " fault"}, 32'(s_fault), 32'(v.e_fault));
        chk({tag, " count"}, s_cnt, v.e_cnt);
        if (v.e_valid) begin
            chk({tag, " out_pc"}, s_pc, v.e_pc);
            chk({tag, " out_instr"}, s_instr, imem(v.e_pc));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, " m_addr"}, m_addr, 32'd0);
        chk({tag, " m_instr"}, m_instr, 32'd0);
        chk({tag, " m_pc"}, m_pc, 32'd0);
        chk({tag, " m_pc4"}, m_pc4, 32'd0);
        chk({tag, " m_fault"}, 32'(m_fault), 32'd0);
        chk({tag, " m_cnt"}, m_cnt, 32'd0);
        chk({tag, " s_valid"}, 32'(s_valid), 32'd0);
        chk({tag, " s_addr"}, s_addr, 32'd0);
        chk({tag, " s_cnt"}, s_cnt, 32'd0);
    endtask

    // Drive inputs, take one clock edge, sample 1 ns later.
    task automatic step(input logic r, input logic d, input logic [31:0] t);
        out_ready       = r;
        redirect_valid  = d;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[22];
    vec_t sv;

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

        vecs[0]  = mk(1, 0, 32'h0,   0, 32'h0,   32'h0,   0, 0);
        vecs[1]  = mk(1, 0, 32'h0,   1, 32'h0,   32'h4,   0, 0);
        vecs[2]  = mk(1, 0, 32'h0,   1, 32'h4,   32'h8,   0, 1);
        vecs[3]  = mk(1, 0, 32'h0,   1, 32'h8,   32'hC,   0, 2);
        vecs[4]  = mk(0, 0, 32'h0,   1, 32'h8,   32'hC,   0, 2);
        vecs[5]  = mk(0, 0, 32'h0,   1, 32'h8,   32'hC,   0, 2);
        vecs[6]  = mk(0, 0, 32'h0,   1, 32'h8,   32'hC,   0, 2);
        vecs[7]  = mk(1, 0, 32'h0,   1, 32'hC,   32'h10,  0, 3);
        vecs[8]  = mk(0, 1, 32'h40,  0, 32'h0,   32'h40,  0, 3);
        vecs[9]  = mk(1, 0, 32'h0,   1, 32'h40,  32'h44,  0, 3);
        vecs[10] = mk(1, 1, 32'h80,  0, 32'h0,   32'h80,  0, 4);
        vecs[11] = mk(0, 0, 32'h0,   1, 32'h80,  32'h84,  0, 4);
        vecs[12] = mk(1, 0, 32'h0,   1, 32'h84,  32'h88,  0, 5);
        vecs[13] = mk(1, 1, 32'h1FC, 0, 32'h0,   32'h1FC, 0, 6);
        vecs[14] = mk(0, 0, 32'h0,   1, 32'h1FC, 32'h200, 0, 6);
        vecs[15] = mk(0, 0, 32'h0,   1, 32'h1FC, 32'h200, 1, 6);
        vecs[16] = mk(1, 0, 32'h0,   0, 32'h0,   32'h200, 1, 7);
        vecs[17] = mk(1, 0, 32'h0,   0, 32'h0,   32'h200, 1, 7);
        vecs[18] = mk(1, 1, 32'h10,  0, 32'h0,   32'h10,  0, 7);
        vecs[19] = mk(1, 0, 32'h0,   1, 32'h10,  32'h14,  0, 7);
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs[20] = mk(1, 1, 32'h42,  0, 32'h0,   32'h42,  1, 8);
        vecs[21] = mk(1, 0, 32'h0,   0, 32'h0,   32'h42,  1, 8);
`else
        vecs[20] = mk(1, 1, 32'h42,  0, 32'h0,   32'h40,  0, 8);
        vecs[21] = mk(1, 0, 32'h0,   1, 32'h40,  32'h44,  0, 8);
`endif

        // Held in reset across a few edges.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        $display("reset: addr=%h valid=%b cnt=%0d", m_addr, m_valid, m_cnt);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
            check_main($sformatf("vec%0d", i), vecs[i]);
            $display("vec %0d: rdy=%b redir=%b tgt=%h -> valid=%b pc=%h addr=%h fault=%b cnt=%0d",
                     i, vecs[i].rdy, vecs[i].redir, vecs[i].tgt, m_valid, m_pc, m_addr, m_fault, m_cnt);
        end

        // Asynchronous reset mid-stream, checked before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        $display("async reset: addr=%h valid=%b fault=%b cnt=%0d", m_addr, m_valid, m_fault, m_cnt);
        @(posedge clk);
        #1;
        out_ready = 1'b1; redirect_valid = 1'b0;
        rst_n = 1'b1;

        // Small instance: run off the end of a 4-word memory, then recover.
        step(1, 0, 32'h0);   // BOOT -> RUN
        step(1, 0, 32'h0);   // out_pc 0
        step(1, 0, 32'h0);   // out_pc 4
        step(1, 0, 32'h0);   // out_pc 8
        step(1, 0, 32'h0);
        sv = mk(1, 0, 32'h0, 1, 32'hC, 32'h10, 0, 3);
        check_small("small_last", sv);
        $display("small: valid=%b pc=%h fault=%b", s_valid, s_pc, s_fault);
        step(1, 0, 32'h0);
        sv = mk(1, 0, 32'h0, 0, 32'h0, 32'h10, 1, 4);
        check_small("small_fault", sv);
        $display("small: valid=%b fault=%b", s_valid, s_fault);
        step(1, 0, 32'h0);
        check_small("small_sticky", sv);
        $display("small: valid=%b fault=%b", s_valid, s_fault);
        step(1, 1, 32'h0);
        sv = mk(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 4);
        check_small("small_redirect", sv);
        $display("small: valid=%b fault=%b addr=%h", s_valid, s_fault, s_addr);
        step(1, 0, 32'h0);
        sv = mk(1, 0, 32'h0, 1, 32'h0, 32'h4, 0, 4);
        check_small("small_resume", sv);
        $display("small: valid=%b pc=%h fault=%b", s_valid, s_pc, s_fault);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
